// File: rtl/cnn_mem_responder_if.sv
// Signal bundle between the processor/host side and cnn_mem_responder.
// Processor request and host preload signals go in one direction.
// The response signals come back the other way.
interface cnn_mem_responder_if;
    logic        req;
    logic        we;
    logic [11:0] address;
    logic [15:0] to_memory;
    logic        ld_en;
    logic [11:0] ld_addr;
    logic [15:0] ld_data;
    logic [15:0] from_memory;
    logic        mem_ready;
    logic        busy;

    modport master (
        output req, we, address, to_memory, ld_en, ld_addr, ld_data,
        input  from_memory, mem_ready, busy
    );

    modport slave (
        input  req, we, address, to_memory, ld_en, ld_addr, ld_data,
        output from_memory, mem_ready, busy
    );
endinterface

// File: rtl/cnn_mem_responder.sv
// Behavioural word memory with a wait-state request/response handshake.
// A sampled request waits WAIT_CYCLES cycles and then answers in a one-cycle RESP state.
// A host preload port can write the array in any state.
module cnn_mem_responder #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned DEPTH       = 4096
) (
    input  logic               clk,
    input  logic               rst,
    cnn_mem_responder_if.slave bus
);
    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] rdata_q, rdata_d;
    logic [11:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] mem_q [DEPTH];
    logic [15:0] mem_rd;

    // Addresses wrap modulo DEPTH, so no out-of-range access is possible.
    function automatic logic [AW-1:0] wrap_addr(input logic [11:0] a);
        int unsigned idx;
        idx = 32'(a) % DEPTH;
        return idx[AW-1:0];
    endfunction

    // Next state, counter, captured request and read-data hold register.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        mem_rd  = mem_q[wrap_addr(addr_q)];
        case (state_q)
            ST_IDLE: begin
                if (bus.req) begin
                    addr_d  = bus.address;
                    we_d    = bus.we;
                    wdata_d = bus.to_memory;
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                // A read keeps driving its value after RESP ends.
                if (!we_q) begin
                    rdata_d = mem_rd;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state and the visible read data are cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // The captured transaction fields are only read while busy, so they need no reset.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        we_q    <= we_d;
        wdata_q <= wdata_d;
    end

    // Preload first, then the transaction write, so the transaction wins a same-address collision.
    // Reset forces IDLE at once, so an aborted write can never reach the array.
    always_ff @(posedge clk) begin
        if (bus.ld_en) begin
            mem_q[wrap_addr(bus.ld_addr)] <= bus.ld_data;
        end
        if (state_q == ST_RESP && we_q) begin
            mem_q[wrap_addr(addr_q)] <= wdata_q;
        end
    end

    assign bus.mem_ready   = (state_q == ST_RESP);
    assign bus.busy        = (state_q != ST_IDLE);
    assign bus.from_memory = (state_q == ST_RESP && !we_q) ? mem_rd : rdata_q;
endmodule

// File: tb/tb_cnn_mem_responder.sv
// Self-checking bench for cnn_mem_responder.
// dut_a uses WAIT_CYCLES=2 and dut_b uses WAIT_CYCLES=0.
// Expected values come from per-DUT memory arrays and the latency rule WAIT_CYCLES+1.
module tb_cnn_mem_responder;
    localparam int WC_A = 2;
    localparam int WC_B = 0;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cnn_mem_responder_if a_if ();
    cnn_mem_responder_if b_if ();

    cnn_mem_responder #(.WAIT_CYCLES(WC_A), .DEPTH(4096)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    cnn_mem_responder #(.WAIT_CYCLES(WC_B), .DEPTH(4096)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] model_a [4096];
    logic [15:0] model_b [4096];
    logic [15:0] last_rd_a;

    bit          r_we;
    bit          r_ld;
    logic [11:0] r_addr;
    logic [11:0] r_laddr;
    logic [15:0] r_data;
    logic [15:0] r_ldata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic preload_a(input logic [11:0] a, input logic [15:0] d);
        a_if.ld_en   = 1'b1;
        a_if.ld_addr = a;
        a_if.ld_data = d;
        @(negedge clk);
        a_if.ld_en   = 1'b0;
        model_a[a]   = d;
    endtask

    task automatic preload_b(input logic [11:0] a, input logic [15:0] d);
        b_if.ld_en   = 1'b1;
        b_if.ld_addr = a;
        b_if.ld_data = d;
        @(negedge clk);
        b_if.ld_en   = 1'b0;
        model_b[a]   = d;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".a_rdy"},  32'(a_if.mem_ready),   32'd0);
        check({tag, ".a_busy"}, 32'(a_if.busy),        32'd0);
        check({tag, ".a_data"}, 32'(a_if.from_memory), 32'd0);
        check({tag, ".b_rdy"},  32'(b_if.mem_ready),   32'd0);
        check({tag, ".b_busy"}, 32'(b_if.busy),        32'd0);
        check({tag, ".b_data"}, 32'(b_if.from_memory), 32'd0);
    endtask

    // One full transaction on dut_a, starting at a falling edge. Optionally the
    // preload port fires in the RESP cycle. Inputs are scrambled after sampling.
    task automatic txn_a(input bit w, input logic [11:0] a, input logic [15:0] d,
                         input bit ld, input logic [11:0] la, input logic [15:0] ldd,
                         input string tag);
        int          lat;
        logic [15:0] exp_rd;
        a_if.req       = 1'b1;
        a_if.we        = w;
        a_if.address   = a;
        a_if.to_memory = d;
        @(negedge clk);
        a_if.req       = 1'b0;
        a_if.we        = 1'($urandom);
        a_if.address   = 12'($urandom);
        a_if.to_memory = 16'($urandom);
        lat = 1;
        while (a_if.mem_ready !== 1'b1 && lat <= 20) begin
            check({tag, ".busy_wait"}, 32'(a_if.busy), 32'd1);
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), 32'(WC_A + 1));
        check({tag, ".busy_resp"}, 32'(a_if.busy), 32'd1);
        exp_rd = w ? last_rd_a : model_a[a];
        check({tag, ".data"}, 32'(a_if.from_memory), 32'(exp_rd));
        last_rd_a = exp_rd;
        if (ld) begin
            a_if.ld_en   = 1'b1;
            a_if.ld_addr = la;
            a_if.ld_data = ldd;
            model_a[la]  = ldd;
        end
        if (w) begin
            model_a[a] = d;
        end
        @(negedge clk);
        a_if.ld_en = 1'b0;
        check({tag, ".rdy_after"},  32'(a_if.mem_ready),   32'd0);
        check({tag, ".busy_after"}, 32'(a_if.busy),        32'd0);
        check({tag, ".data_hold"},  32'(a_if.from_memory), 32'(last_rd_a));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t;
        logic [11:0] exp_addr;
        rst            = 1'b0;
        a_if.req       = 1'b0;
        a_if.we        = 1'b0;
        a_if.address   = 12'h000;
        a_if.to_memory = 16'h0000;
        a_if.ld_en     = 1'b0;
        a_if.ld_addr   = 12'h000;
        a_if.ld_data   = 16'h0000;
        b_if.req       = 1'b0;
        b_if.we        = 1'b0;
        b_if.address   = 12'h000;
        b_if.to_memory = 16'h0000;
        b_if.ld_en     = 1'b0;
        b_if.ld_addr   = 12'h000;
        b_if.ld_data   = 16'h0000;
        last_rd_a      = 16'h0000;

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        // Preloaded read with the documented latency.
        preload_a(12'h010, 16'hABCD);
        txn_a(1'b0, 12'h010, 16'h0000, 1'b0, 12'h000, 16'h0000, "rd010");

        // Write to the top address, then read it back.
        txn_a(1'b1, 12'hFFF, 16'h1234, 1'b0, 12'h000, 16'h0000, "wrFFF");
        txn_a(1'b0, 12'hFFF, 16'h0000, 1'b0, 12'h000, 16'h0000, "rdFFF");

        // Back-to-back reads with zero wait states and req held high.
        preload_b(12'h001, 16'h0001);
        preload_b(12'h002, 16'h0002);
        b_if.req     = 1'b1;
        b_if.we      = 1'b0;
        b_if.address = 12'h001;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            t        = (k - 1) / (WC_B + 2);
            exp_addr = (t % 2 == 0) ? 12'h001 : 12'h002;
            if ((k - 1) % (WC_B + 2) == WC_B) begin
                check("b2b.rdy", 32'(b_if.mem_ready), 32'd1);
                check("b2b.data", 32'(b_if.from_memory), 32'(model_b[exp_addr]));
                b_if.address = (exp_addr == 12'h001) ? 12'h002 : 12'h001;
            end else begin
                check("b2b.idle", 32'(b_if.mem_ready), 32'd0);
                check("b2b.hold", 32'(b_if.from_memory), 32'(model_b[exp_addr]));
            end
            if (k == 6) begin
                b_if.req = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b.stop", 32'(b_if.mem_ready), 32'd0);

        // Reset during WAIT aborts the pending write.
        preload_a(12'h020, 16'h7777);
        a_if.req       = 1'b1;
        a_if.we        = 1'b1;
        a_if.address   = 12'h020;
        a_if.to_memory = 16'h5555;
        @(negedge clk);
        a_if.req = 1'b0;
        check("abort.in_wait", 32'(a_if.busy), 32'd1);
        rst = 1'b0;
        #1;
        check_reset_outputs("abort_rst");
        @(negedge clk);
        rst       = 1'b1;
        last_rd_a = 16'h0000;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("abort.no_rdy", 32'(a_if.mem_ready), 32'd0);
        end
        txn_a(1'b0, 12'h020, 16'h0000, 1'b0, 12'h000, 16'h0000, "abort_rd");

        // Preload collisions.
        txn_a(1'b1, 12'h030, 16'h00AA, 1'b1, 12'h030, 16'h00BB, "coll_wr");
        txn_a(1'b0, 12'h030, 16'h0000, 1'b0, 12'h000, 16'h0000, "coll_rd030");
        preload_a(12'h031, 16'h4444);
        txn_a(1'b0, 12'h031, 16'h0000, 1'b1, 12'h031, 16'h9999, "coll_rd031");
        txn_a(1'b0, 12'h031, 16'h0000, 1'b0, 12'h000, 16'h0000, "coll_rd031b");

        // Randomized traffic over a small preloaded window to force address reuse.
        for (int i = 0; i < 16; i++) begin
            preload_a(12'h100 + 12'(i), 16'($urandom));
        end
        for (int i = 0; i < 40; i++) begin
            r_we    = 1'($urandom);
            r_addr  = 12'h100 + 12'($urandom % 16);
            r_data  = 16'($urandom);
            r_ld    = ($urandom % 3 == 0);
            r_laddr = ($urandom % 2 == 0) ? r_addr : (12'h100 + 12'($urandom % 16));
            r_ldata = 16'($urandom);
            txn_a(r_we, r_addr, r_data, r_ld, r_laddr, r_ldata, "rand");
            repeat ($urandom % 3) @(negedge clk);
        end
        for (int i = 0; i < 16; i++) begin
            txn_a(1'b0, 12'h100 + 12'(i), 16'h0000, 1'b0, 12'h000, 16'h0000, "sweep");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/cnn_mem_responder.md
CNN_MEM_RESPONDER -- requirements
Module: cnn_mem_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, number of wait states inserted before each response (legal range 0..15).
REQ-002 Parameter DEPTH, default 4096, number of 16-bit words stored.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req  input  1  level request from processor; sampled only in IDLE.
REQ-006 we  input  1  1 = write transaction, 0 = read; sampled with req.
REQ-007 address  input  12  word address; sampled with req.
REQ-008 to_memory  input  16  write data from processor; sampled with req.
REQ-009 ld_en  input  1  host preload strobe; writes one word per asserted cycle.
REQ-010 ld_addr  input  12  preload word address.
REQ-011 ld_data  input  16  preload data.
REQ-012 from_memory  output  16  read data returned to processor.
REQ-013 mem_ready  output  1  one-cycle completion pulse for read or write.
REQ-014 busy  output  1  high while a transaction is in WAIT or RESP.

Function
REQ-015 The block SHALL implement a three-state FSM: IDLE, WAIT, RESP.
REQ-016 IDLE: on a rising edge with req=1, the block SHALL latch address, we, and to_memory, load the wait counter with WAIT_CYCLES, and go to WAIT, or to RESP when WAIT_CYCLES=0.
REQ-017 WAIT: the counter SHALL decrement by 1 each cycle; the FSM SHALL go to RESP on the edge where the counter is 1.
REQ-018 RESP: for one cycle the block SHALL assert mem_ready=1 and return to IDLE on the next edge.
REQ-019 RESP read: from_memory SHALL equal mem[latched address] in the RESP cycle and SHALL hold until the next read response.
REQ-020 RESP write: mem[latched address] SHALL be updated with latched data at the RESP→IDLE edge; from_memory SHALL remain unchanged.
REQ-021 Latency: mem_ready SHALL be high in the cycle exactly WAIT_CYCLES+1 cycles after the edge that sampled req.
REQ-022 Changes to req, we, address, or to_memory after sampling SHALL have no effect on the current transaction.
REQ-023 A req held high through RESP SHALL start a new transaction at the first IDLE edge, with no bubble beyond the IDLE cycle.
REQ-024 busy SHALL be 1 in WAIT and RESP and 0 in IDLE.
REQ-025 ld_en=1 SHALL write ld_data to mem[ld_addr] on that edge, in any state.
REQ-026 If a RESP write and ld_en target the same address on the same edge, the transaction write SHALL win.
REQ-027 If a RESP read and ld_en target the same address in the same cycle, the read SHALL return the pre-write value.
REQ-028 Address indices SHALL be taken modulo DEPTH; no out-of-range error is signalled.

Reset
REQ-029 rst=0 SHALL immediately force state=IDLE, mem_ready=0, busy=0, from_memory=16'h0000, and counter=0.
REQ-030 Memory contents SHALL NOT be cleared by reset.
REQ-031 Reset during WAIT or RESP SHALL abort the transaction; a pending write SHALL NOT reach memory, and no mem_ready pulse SHALL follow.
REQ-032 After rst returns high, the first edge with req=1 SHALL start a new transaction normally.

Verification
REQ-033 Preload mem[12'h010]=16'hABCD; read 12'h010 with WAIT_CYCLES=2 -> mem_ready high exactly 3 cycles after the sample edge, from_memory=16'hABCD, busy high for 3 cycles.
REQ-034 Write 16'h1234 to 12'hFFF, then read 12'hFFF -> second mem_ready returns 16'h1234; from_memory unchanged during the write response.
REQ-035 WAIT_CYCLES=0 with req held high for 6 cycles, alternating addresses 1 and 2 (preloaded 16'h0001 and 16'h0002) -> mem_ready pulses every 2nd cycle, returning 16'h0001 then 16'h0002 alternately.
REQ-036 Issue a write of 16'h5555 to 12'h020, then assert rst low for 1 cycle during WAIT -> no mem_ready; subsequent read of 12'h020 returns its old value; all outputs are 0 while rst is low.
REQ-037 Write 16'h00AA and ld_en with 16'h00BB on the same edge to 12'h030 -> later read returns 16'h00AA; RESP read of 12'h031 with ld_en to 12'h031 in the same cycle returns the old value.
